// File: rtl/nkmd_prog_pkg.sv
// nkmd program loader: shared types and constants.
// Optional checksum check is enabled by NKMD_PROG_LOADER_CKSUM_EN.
package nkmd_prog_pkg;

  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/nkmd_prog_if.sv
// Byte stream from the host link into the nkmd program loader.
// Valid/ready handshake, one byte per accepted cycle.
interface nkmd_prog_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;

  modport master (
    output rx_data_i,
    output rx_valid_i,
    input  rx_ready_o
  );

  modport slave (
    input  rx_data_i,
    input  rx_valid_i,
    output rx_ready_o
  );
endinterface

// File: rtl/nkmd_prog_wordasm.sv
// 8->32 big-endian word assembler with byte counter.
// word_o is the full word on the cycle the 4th byte is shifted.
module nkmd_prog_wordasm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= {sr[15:0], din};
      cnt <= cnt + 2'd1;
    end
  end

  assign word_o      = {sr, din};
  assign word_done_o = shift_en && (cnt == 2'd3);

endmodule

// File: rtl/nkmd_prog_loader.sv
// nkmd program RAM loader: framed byte stream -> word writes.
// Build with NKMD_PROG_LOADER_CKSUM_EN to verify the frame checksum.
module nkmd_prog_loader
  import nkmd_prog_pkg::*;
#(
  parameter int         WIDTH = 1024,
  parameter logic [7:0] MAGIC = MAGIC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  nkmd_prog_if.slave  rx,
  output logic [31:0] prog_addr_o,
  output logic [31:0] prog_data_o,
  output logic        prog_ack_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  state_t state, nxt;

  logic [7:0]       len_hi;
  logic [LEN_W-1:0] n_len;
  logic [LEN_W-1:0] widx;
  logic [LEN_W:0]   widx_nx;
  logic [LEN_W-1:0] len_now;
  logic             accept;
  logic             is_magic;
  logic             last_word;
  logic             cks_ok;
  logic [31:0]      word;
  logic             word_done;

  assign rx.rx_ready_o = !(state inside {S_WRITE, S_DONE, S_ERR});
  assign accept    = rx.rx_valid_i && rx.rx_ready_o;
  assign is_magic  = accept && (state == S_IDLE) && (rx.rx_data_i == MAGIC);
  assign len_now   = {len_hi, rx.rx_data_i};
  assign widx_nx   = {1'b0, widx} + 1'b1;
  assign last_word = (widx_nx == {1'b0, n_len});

  nkmd_prog_wordasm u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (state == S_LEN_LO),
    .shift_en    (accept && (state == S_DATA)),
    .din         (rx.rx_data_i),
    .word_o      (word),
    .word_done_o (word_done)
  );

`ifdef NKMD_PROG_LOADER_CKSUM_EN
  logic [7:0] sum;

  // Running sum of length and data; the trailer must bring it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (is_magic) begin
      sum <= '0;
    end else if (accept &&
                 (state inside {S_LEN_HI, S_LEN_LO, S_DATA})) begin
      sum <= sum + rx.rx_data_i;
    end
  end

  assign cks_ok = ((sum + rx.rx_data_i) == 8'h00);
`else
  assign cks_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (is_magic) nxt = S_LEN_HI;
      S_LEN_HI: if (accept) nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_now == '0)
            nxt = S_CKSUM;
          else if ({1'b0, len_now} > (LEN_W+1)'(WIDTH))
            nxt = S_ERR;
          else
            nxt = S_DATA;
        end
      end
      S_DATA:   if (word_done) nxt = S_WRITE;
      S_WRITE:  nxt = last_word ? S_CKSUM : S_DATA;
      S_CKSUM:  if (accept) nxt = cks_ok ? S_DONE : S_ERR;
      S_DONE:   nxt = S_IDLE;
      S_ERR:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi      <= '0;
      n_len       <= '0;
      widx        <= '0;
      prog_addr_o <= '0;
      prog_data_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if (accept && (state == S_LEN_HI))
        len_hi <= rx.rx_data_i;
      if (accept && (state == S_LEN_LO)) begin
        n_len <= len_now;
        widx  <= '0;
      end
      // Address/data are staged so they are stable during the strobe.
      if (word_done) begin
        prog_data_o <= word;
        prog_addr_o <= {{(32-LEN_W){1'b0}}, widx};
      end
      if (state == S_WRITE)
        widx <= widx_nx[LEN_W-1:0];
      if (is_magic)
        err_o <= 1'b0;
      else if (nxt == S_ERR)
        err_o <= 1'b1;
    end
  end

  assign prog_ack_o = (state == S_WRITE);
  assign done_o     = (state == S_DONE);
  assign cpu_hold_o = state inside {S_LEN_HI, S_LEN_LO, S_DATA,
                                    S_WRITE, S_CKSUM};

endmodule

// File: tb/tb_nkmd_prog_loader.sv
// Directed bench for nkmd_prog_loader with a write scoreboard.
// Checksum expectations follow NKMD_PROG_LOADER_CKSUM_EN.
module tb_nkmd_prog_loader;

  localparam int WIDTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] prog_addr_o;
  logic [31:0] prog_data_o;
  logic        prog_ack_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  nkmd_prog_if bus ();

  nkmd_prog_loader #(
    .WIDTH (WIDTH),
    .MAGIC (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (bus),
    .prog_addr_o (prog_addr_o),
    .prog_data_o (prog_data_o),
    .prog_ack_o  (prog_ack_o),
    .cpu_hold_o  (cpu_hold_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [63:0] exp_q[$];
  logic [31:0] wq[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and handshake monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prog_ack_o) begin
        ack_cnt++;
        check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("prog_addr", prog_addr_o, e[63:32]);
          check("prog_data", prog_data_o, e[31:0]);
        end
      end
      if (cpu_hold_o)
        check("ready_vs_write", 32'(bus.rx_ready_o),
              32'(!prog_ack_o));
      if (done_o) done_cnt++;
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    int g;
    g = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    while (bus.rx_ready_o !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("accept_timeout", 32'(g), 32'd0);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gaps,
                            input logic [7:0] delta);
    logic [7:0] s;
    logic [7:0] b;
    logic [15:0] len;
    len = 16'(n);
    s = len[15:8] + len[7:0];
    send(8'hA5, gaps);
    #1;
    check("hold_on_magic", 32'(cpu_hold_o), 32'd1);
    check("err_clr_magic", 32'(err_o), 32'd0);
    send(len[15:8], gaps);
    send(len[7:0], gaps);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = wq[k][31-8*j -: 8];
        s = s + b;
        if (j == 3) exp_q.push_back({32'(k), wq[k]});
        send(b, gaps);
      end
    end
    send((8'h00 - s) + delta, gaps);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.rx_ready_o), 32'd1);
    check("rst_ack", 32'(prog_ack_o), 32'd0);
    check("rst_hold", 32'(cpu_hold_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_addr", prog_addr_o, 32'd0);
    check("rst_data", prog_data_o, 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);

    // Two-word frame from the plan.
    wq = '{32'h11223344, 32'hDEADBEEF};
    send_frame(2, 1'b0, 8'h00);
    #1;
    check("f1_done", 32'(done_o), 32'd1);
    check("f1_hold", 32'(cpu_hold_o), 32'd0);
    check("f1_err", 32'(err_o), 32'd0);
    check("f1_acks", 32'(ack_cnt), 32'd2);
    exp_done++;
    idle();

    // Zero-length frame.
    wq = {};
    send_frame(0, 1'b0, 8'h00);
    #1;
    check("f0_done", 32'(done_o), 32'd1);
    check("f0_acks", 32'(ack_cnt), 32'd2);
    exp_done++;
    idle();

    // WIDTH+1 words is rejected.
    send(8'hA5, 1'b0);
    send(8'h04, 1'b0);
    send(8'h01, 1'b0);
    #1;
    check("big_err", 32'(err_o), 32'd1);
    check("big_hold", 32'(cpu_hold_o), 32'd0);
    check("big_done", 32'(done_o), 32'd0);
    idle();
    repeat (3) @(negedge clk);
    check("big_sticky", 32'(err_o), 32'd1);
    check("big_acks", 32'(ack_cnt), 32'd2);

    // Next good frame clears err_o and loads.
    wq = '{32'hCAFEF00D};
    send_frame(1, 1'b0, 8'h00);
    #1;
    check("rec_done", 32'(done_o), 32'd1);
    check("rec_acks", 32'(ack_cnt), 32'd3);
    exp_done++;
    idle();
    repeat (2) @(negedge clk);
    check("hold_addr", prog_addr_o, 32'd0);
    check("hold_data", prog_data_o, 32'hCAFEF00D);

    // Random valid gaps.
    wq = '{$urandom, $urandom, $urandom};
    send_frame(3, 1'b1, 8'h00);
    #1;
    check("gap_done", 32'(done_o), 32'd1);
    check("gap_acks", 32'(ack_cnt), 32'd6);
    exp_done++;
    idle();

    // Reset after two data bytes.
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_valid_i = 1'b0;
    #1;
    check("mid_rst_addr", prog_addr_o, 32'd0);
    check("mid_rst_data", prog_data_o, 32'd0);
    check("mid_rst_ack", 32'(prog_ack_o), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold_o), 32'd0);
    check("mid_rst_ready", 32'(bus.rx_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    check("mid_rst_noack", 32'(ack_cnt), 32'd6);
    check("mid_rst_idle", 32'(cpu_hold_o), 32'd0);

    wq = '{32'h01020304};
    send_frame(1, 1'b0, 8'h00);
    #1;
    check("post_rst_done", 32'(done_o), 32'd1);
    check("post_rst_acks", 32'(ack_cnt), 32'd7);
    exp_done++;
    idle();

    // Corrupted checksum.
    wq = '{32'hA0B0C0D0, 32'h0E0F1011};
    send_frame(2, 1'b0, 8'h01);
    #1;
    check("cs_acks", 32'(ack_cnt), 32'd9);
    check("cs_hold", 32'(cpu_hold_o), 32'd0);
`ifdef NKMD_PROG_LOADER_CKSUM_EN
    check("cs_err", 32'(err_o), 32'd1);
    check("cs_done", 32'(done_o), 32'd0);
`else
    check("cs_err", 32'(err_o), 32'd0);
    check("cs_done", 32'(done_o), 32'd1);
    exp_done++;
`endif
    idle();

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
